// File: rtl/accum_alu_seq.sv
// accum_alu_seq: parametrised accumulator ALU with valid/ready issue and a
// multi-cycle shift-add multiply. `result` is the live accumulator.
// Optional feature macro: ACCUM_ALU_FLAGS_EN adds a registered {carry, zero}
// `flags` output that is written on the same edge as the accumulator.
module accum_alu_seq #(
    parameter int DATA_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_W-1:0]     a,
    output logic                  out_valid,
    output logic [2*DATA_W-1:0]   result,
    output logic                  busy
`ifdef ACCUM_ALU_FLAGS_EN
    ,
    output logic [1:0]            flags
`endif
);

    localparam int ACC_W  = 2 * DATA_W;
    localparam int SUM_W  = DATA_W + 1;
    localparam int WIDE_W = ACC_W + 1;
    localparam int CNT_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ACC_W-1:0]    acc_q;
    logic                out_valid_q;

    // Multiply datapath: the multiplicand shifts left and the multiplier
    // shifts right each step, so bit 0 of mplier_q is always "bit[counter]".
    logic [ACC_W-1:0]    mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [ACC_W-1:0]    prod_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                accept;
    logic                mul_last;
    logic [DATA_W-1:0]   acc_l;
    logic [ACC_W-1:0]    alu_res;
    logic                alu_carry;
    logic [ACC_W-1:0]    prod_step;

    assign acc_l     = acc_q[DATA_W-1:0];
    assign in_ready  = (state_q == IDLE);
    assign busy      = ~in_ready;
    assign result    = acc_q;
    assign out_valid = out_valid_q;
    assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

    // Next-state logic: accept only in IDLE, leave MUL after DATA_W steps.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        accept   = 1'b0;
        mul_last = 1'b0;
        case (state_q)
            IDLE: begin
                accept = in_valid;
                if (in_valid && (op == OP_MUL)) begin
                    state_d = MUL;
                end
            end
            MUL: begin
                mul_last = (cnt_q == CNT_LAST);
                if (mul_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single-cycle ALU result and carry for the opcode being accepted.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            3'b000: alu_res = ACC_W'({1'b0, a} + SUM_W'(1));
            3'b001: alu_res = ACC_W'({1'b0, a} + {1'b0, acc_l});
            3'b010: {alu_carry, alu_res} = {1'b0, acc_q} + WIDE_W'(a);
            3'b011: alu_res = {a | acc_l, a ^ acc_l};
            3'b100: alu_res = ACC_W'(|{a, acc_l});
            3'b101: alu_res = ACC_W'(acc_l) << a;
            3'b110: alu_res = ACC_W'(acc_l) >> a;
            default: alu_res = acc_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator, completion pulse and shift-add multiply datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept) begin
                if (op == OP_MUL) begin
                    mcand_q  <= ACC_W'(acc_l);
                    mplier_q <= a;
                    prod_q   <= '0;
                    cnt_q    <= '0;
                end else begin
                    acc_q       <= alu_res;
                    out_valid_q <= 1'b1;
                end
            end else if (state_q == MUL) begin
                prod_q   <= prod_step;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CNT_W'(1);
                if (mul_last) begin
                    acc_q       <= prod_step;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

`ifdef ACCUM_ALU_FLAGS_EN
    logic [1:0] flags_q;

    assign flags = flags_q;

    // Flags follow the accumulator write; carry only comes from op 010.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 2'b00;
        end else if (accept && (op != OP_MUL)) begin
            flags_q <= {alu_carry, (alu_res == '0)};
        end else if ((state_q == MUL) && mul_last) begin
            flags_q <= {1'b0, (prod_step == '0)};
        end
    end
`endif

endmodule

// File: tb/tb_accum_alu_seq.sv
// Self-checking bench for accum_alu_seq (DATA_W=4): directed vector table,
// hand-written multiply/abort sequences, then random traffic against an
// arithmetic reference model.
module tb_accum_alu_seq;

    localparam int DW = 4;
    localparam int AW = 2 * DW;
    localparam int L_MOD = 1 << DW;
    localparam int A_MOD = 1 << AW;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic          out_valid;
    logic [AW-1:0] result;
    logic          busy;
`ifdef ACCUM_ALU_FLAGS_EN
    logic [1:0]    flags;
`endif

    accum_alu_seq #(.DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .out_valid (out_valid),
        .result    (result),
        .busy      (busy)
`ifdef ACCUM_ALU_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain arithmetic on integers, multiply as a countdown.
    int m_acc   = 0;
    int m_busy  = 0;
    int m_prod  = 0;
    int m_flags = 0;
    bit m_ov    = 0;

    task automatic model_step(input bit rst, input bit v, input int o, input int av);
        int l;
        int sum;
        int carry;
        l = m_acc % L_MOD;
        carry = 0;
        if (rst) begin
            m_acc = 0; m_busy = 0; m_ov = 0; m_flags = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            m_ov = (m_busy == 0);
            if (m_busy == 0) begin
                m_acc = m_prod;
                m_flags = (m_acc == 0) ? 1 : 0;
            end
        end else if (v) begin
            m_ov = 1;
            case (o)
                0: m_acc = av + 1;
                1: m_acc = av + l;
                2: begin
                    sum = m_acc + av;
                    carry = (sum >= A_MOD) ? 1 : 0;
                    m_acc = sum % A_MOD;
                end
                3: m_acc = ((av | l) * L_MOD) + (av ^ l);
                4: m_acc = (av != 0 || l != 0) ? 1 : 0;
                5: m_acc = (av >= AW) ? 0 : ((l << av) % A_MOD);
                6: m_acc = l >> av;
                default: begin
                    m_prod = av * l;
                    m_busy = DW;
                    m_ov = 0;
                end
            endcase
            if (o != 7) m_flags = carry * 2 + ((m_acc == 0) ? 1 : 0);
        end else begin
            m_ov = 0;
        end
    endtask

    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] a;
        logic [AW-1:0] res;
        logic [1:0]    flg;
    } vec_t;

    vec_t vecs[17];

    initial begin
        // Back-to-back single-cycle ops from acc=0 after reset.
        vecs[0]  = '{3'd0, 4'hF, 8'h10, 2'b00};
        vecs[1]  = '{3'd1, 4'hC, 8'h0C, 2'b00};
        vecs[2]  = '{3'd1, 4'h5, 8'h11, 2'b00};
        vecs[3]  = '{3'd0, 4'h2, 8'h03, 2'b00};
        vecs[4]  = '{3'd5, 4'h5, 8'h60, 2'b00};
        vecs[5]  = '{3'd5, 4'h9, 8'h00, 2'b01};
        vecs[6]  = '{3'd0, 4'hB, 8'h0C, 2'b00};
        vecs[7]  = '{3'd6, 4'h2, 8'h03, 2'b00};
        vecs[8]  = '{3'd0, 4'h5, 8'h06, 2'b00};
        vecs[9]  = '{3'd3, 4'hA, 8'hEC, 2'b00};
        vecs[10] = '{3'd0, 4'h0, 8'h01, 2'b00};
        vecs[11] = '{3'd3, 4'hF, 8'hFE, 2'b00};
        vecs[12] = '{3'd2, 4'h3, 8'h01, 2'b10};
        vecs[13] = '{3'd6, 4'hF, 8'h00, 2'b01};
        vecs[14] = '{3'd4, 4'h0, 8'h00, 2'b01};
        vecs[15] = '{3'd4, 4'h3, 8'h01, 2'b00};
        vecs[16] = '{3'd2, 4'h5, 8'h06, 2'b00};

        reset = 1'b0; in_valid = 1'b0; op = 3'd0; a = '0;

        // Reset with a live request applied; it must be ignored.
        reset = 1'b1; in_valid = 1'b1; op = 3'd0; a = 4'h5;
        tick();
        check("rst_result", result, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
`ifdef ACCUM_ALU_FLAGS_EN
        check("rst_flags", flags, 2'b00);
`endif
        reset = 1'b0; in_valid = 1'b0;
        tick();
        check("post_rst_out_valid", out_valid, 1'b0);
        check("post_rst_result", result, 8'h00);

        // Vector table, one op per cycle.
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; op = vecs[i].op; a = vecs[i].a;
            tick();
            check($sformatf("vec%0d_result", i), result, vecs[i].res);
            check($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
            check($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
`ifdef ACCUM_ALU_FLAGS_EN
            check($sformatf("vec%0d_flags", i), flags, vecs[i].flg);
`endif
        end

        // Multiply 0xB * 0xD with a request held during busy.
        in_valid = 1'b1; op = 3'd0; a = 4'hA;
        tick();
        check("mul_load", result, 8'h0B);
        op = 3'd7; a = 4'hD;
        tick();
        check("mul_acc_in_ready", in_ready, 1'b0);
        check("mul_acc_busy", busy, 1'b1);
        check("mul_acc_result", result, 8'h0B);
        check("mul_acc_out_valid", out_valid, 1'b0);
        op = 3'd0; a = 4'h1;
        for (int k = 1; k < DW; k++) begin
            tick();
            check($sformatf("mul_busy%0d", k), busy, 1'b1);
            check($sformatf("mul_in_ready%0d", k), in_ready, 1'b0);
            check($sformatf("mul_hold%0d", k), result, 8'h0B);
            check($sformatf("mul_ov%0d", k), out_valid, 1'b0);
        end
        tick();
        check("mul_done_in_ready", in_ready, 1'b1);
        check("mul_done_busy", busy, 1'b0);
        check("mul_done_result", result, 8'h8F);
        check("mul_done_out_valid", out_valid, 1'b1);
`ifdef ACCUM_ALU_FLAGS_EN
        check("mul_done_flags", flags, 2'b00);
`endif
        tick();
        check("held_req_result", result, 8'h02);
        check("held_req_out_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        tick();
        check("idle_out_valid", out_valid, 1'b0);
        check("idle_result", result, 8'h02);

        // Reset two cycles into a multiply aborts it.
        in_valid = 1'b1; op = 3'd0; a = 4'hE;
        tick();
        check("abort_load", result, 8'h0F);
        op = 3'd7; a = 4'hF;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("abort_result", result, 8'h00);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("abort_quiet_ov%0d", k), out_valid, 1'b0);
            check($sformatf("abort_quiet_res%0d", k), result, 8'h00);
            check($sformatf("abort_quiet_rdy%0d", k), in_ready, 1'b1);
        end
        in_valid = 1'b1; op = 3'd0; a = 4'h0;
        tick();
        check("after_abort_result", result, 8'h01);
        check("after_abort_out_valid", out_valid, 1'b1);
        in_valid = 1'b0;

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            bit r;
            bit v;
            int o;
            int av;
            r  = (i == 0) || ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 3) != 0);
            o  = $urandom_range(0, 7);
            av = $urandom_range(0, L_MOD - 1);
            reset = r; in_valid = v; op = 3'(o); a = DW'(av);
            tick();
            model_step(r, v, o, av);
            check("rnd_result", result, 32'(m_acc));
            check("rnd_out_valid", out_valid, 32'(m_ov));
            check("rnd_in_ready", in_ready, (m_busy == 0) ? 1 : 0);
            check("rnd_busy", busy, (m_busy != 0) ? 1 : 0);
`ifdef ACCUM_ALU_FLAGS_EN
            check("rnd_flags", flags, 32'(m_flags));
`endif
        end
        reset = 1'b0; in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/accum_alu_seq.md
Name: accum_alu_seq

Overview:
- Parametrised accumulator ALU, the next generation of the board-level 4-bit-operand / 8-bit-accumulator ALU.
- Operand width is generic, and operations are issued through a valid/ready handshake.
- Multiply is a multi-cycle shift-add sequence instead of a combinational array.
- Sits between switch/bus input logic and the hex/LED display path; `result` is the live accumulator.

Parameters:
- DATA_W, 4: operand width. The accumulator is ACC_W = 2*DATA_W (local, not overridable). DATA_W must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request this cycle
- op  input  3  opcode
- a  input  DATA_W  operand
- out_valid  output  1  one-cycle pulse: `result` was just updated
- result  output  ACC_W  accumulator register
- busy  output  1  multiply in progress (equals ~in_ready)

Behaviour:
- Reset: on any clk edge with reset=1:
  - acc=0, out_valid=0, state=IDLE, in_ready=1, busy=0.
  - Reset overrides every other input, including mid-multiply.
- Accept: an operation is taken at a clk edge where in_valid & in_ready. Let accL = acc[DATA_W-1:0] sampled at that edge.
- Opcodes (widths are exact):
  - 000: acc <= zero-extend(a + 1); DATA_W+1 bit sum.
  - 001: acc <= zero-extend(a + accL); DATA_W+1 bit sum including carry.
  - 010: acc <= acc + zero-extend(a), modulo 2^ACC_W (full-width accumulate, wraps).
  - 011: acc <= {a | accL, a ^ accL}.
  - 100: acc <= zero-extend(|{a, accL}).
  - 101: acc <= zero-extend(accL) << a, truncated to ACC_W; any a >= ACC_W gives 0.
  - 110: acc <= zero-extend(accL) >> a.
  - 111: acc <= a * accL, multi-cycle (see below).
- Single-cycle ops (000-110):
  - acc is written at the accept edge.
  - out_valid=1 for exactly the next cycle.
  - in_ready stays 1, so back-to-back ops are allowed every cycle.
- Multiply state machine:
  - IDLE -> MUL on accepting op 111. At that edge, a and accL are captured into internal registers; the product register is cleared; bit counter = 0.
  - MUL: each cycle, if multiplier bit[counter] is set, add the multiplicand shifted by counter into the product; counter++.
  - After DATA_W MUL cycles: acc <= product and the state returns to IDLE on that edge.
  - out_valid pulses 1 the cycle after. acc is written at accept edge + DATA_W.
  - in_ready=0 and busy=1 for exactly DATA_W cycles after the accept.
  - in_valid, op and a are ignored while busy.
  - acc (and `result`) holds its pre-multiply value until the final write.
- out_valid never asserts twice for one accepted op, and never asserts without an accept.
- Reset during MUL aborts the multiply: acc=0, no out_valid, in_ready=1 in the following cycle.
- in_valid=0: acc holds its value; out_valid=0.

Optional Feature:
- Macro: ACCUM_ALU_FLAGS_EN.
- Defined:
  - Adds output port `flags`, width 2: {carry, zero}, registered and written on the same edge as acc. Reset value 2'b00.
  - zero = (new acc == 0).
  - carry = carry-out of the ACC_W addition for op 010; 0 for all other ops.
  - flags hold their value when no op completes.
- Not defined: the `flags` port and its logic are absent; everything else is identical.

Test Plan (DATA_W=4):
1. Reset: reset=1 for 1 cycle, with op 000 / a=5 / in_valid=1 applied during reset -> result=8'h00, out_valid=0 throughout, in_ready=1.
2. op000 a=4'hF -> result=8'h10 and out_valid=1 in the cycle after accept. Then op001 a=4'hC with accL=0 -> result=8'h0C. Then op001 a=4'h5 (accL=C) -> 8'h11, out_valid pulsing on 3 consecutive cycles.
3. acc=8'h0B, op111 a=4'hD:
   - in_ready=0 and busy=1 for 4 cycles; result stays 8'h0B meanwhile.
   - Then result=8'h8F and out_valid=1 for one cycle.
   - A request held with in_valid=1 during busy (op000 a=1) is accepted only when in_ready returns.
4. Reset 2 cycles after accepting op111 a=4'hF (acc=8'h0F) -> result=8'h00, no out_valid, in_ready=1 the next cycle. A following op000 a=0 gives 8'h01.
5. Shifts:
   - accL=4'h3, op101 a=5 -> 8'h60.
   - op101 a=9 -> 8'h00.
   - accL=4'hC, op110 a=2 -> 8'h03.
   - op011 a=4'hA with accL=4'h6 -> 8'hEC.
6. acc=8'hFE, op010 a=4'h3 -> result=8'h01. With ACCUM_ALU_FLAGS_EN: flags=2'b10. Then op100 a=0 with accL=0 (after loading 8'h00 via op110 a=4'hF) -> result=8'h00, flags=2'b01.
